// File: rtl/cv32e41p_trace_fifo.sv
// Multi-channel retired-instruction trace buffer: round-robin capture from
// NUM_CH non-stallable sources into a shared first-word-fall-through FIFO.
module cv32e41p_trace_fifo #(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    parameter int OVERWRITE = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      capture_en_i,
    input  logic                      clear_i,
    input  logic [NUM_CH-1:0]         ch_valid_i,
    input  logic [NUM_CH*32-1:0]      ch_pc_i,
    input  logic [NUM_CH*32-1:0]      ch_instr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [CH_W-1:0]           out_ch_o,
    output logic [31:0]               out_pc_o,
    output logic [31:0]               out_instr_o,
    output logic [PTR_W:0]            level_o,
    output logic [NUM_CH*CNT_W-1:0]   drop_cnt_o,
    output logic [CNT_W-1:0]          ovf_cnt_o
);

    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam bit             OVW      = (OVERWRITE != 0);

    logic [NUM_CH-1:0] req;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   rr_reg, rr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W:0]    level_reg;
    logic [CNT_W-1:0]  ovf_cnt_reg;
    logic [31:0]       grant_pc, grant_instr;

    logic [31:0]       mem_pc    [DEPTH];
    logic [31:0]       mem_instr [DEPTH];
    logic [CH_W-1:0]   mem_ch    [DEPTH];

    logic full, pop, push, ovw_evict, full_drop;

    assign req = ch_valid_i & {NUM_CH{capture_en_i}};

    // Scan offsets from rr upward; the first requesting channel wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!grant_valid && req[c] && (((int'(rr_reg) + i) % NUM_CH) == c)) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        grant_pc    = '0;
        grant_instr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == CH_W'(c)) begin
                grant_pc    = ch_pc_i[c*32 +: 32];
                grant_instr = ch_instr_i[c*32 +: 32];
            end
        end
    end

    always_comb begin
        rr_next = rr_reg;
        if (grant_valid) begin
            rr_next = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
        end
    end

    assign full        = (level_reg == LVL_FULL);
    assign out_valid_o = (level_reg != '0);
    assign pop         = out_valid_o && out_ready_i && !clear_i;
    // A full FIFO still accepts when the sink frees a slot this cycle.
    assign push        = grant_valid && !clear_i && (!full || pop || OVW);
    assign ovw_evict   = grant_valid && !clear_i && full && !pop && OVW;
    assign full_drop   = grant_valid && !clear_i && full && !pop && !OVW;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            level_reg   <= '0;
            rr_reg      <= '0;
            ovf_cnt_reg <= '0;
        end else if (clear_i) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            level_reg   <= '0;
            rr_reg      <= '0;
            ovf_cnt_reg <= '0;
        end else begin
            rr_reg <= rr_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop || ovw_evict) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop && !ovw_evict) begin
                level_reg <= level_reg + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - (PTR_W+1)'(1);
            end
            if (ovw_evict && ovf_cnt_reg != '1) begin
                ovf_cnt_reg <= ovf_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr_reg]    <= grant_pc;
            mem_instr[wr_ptr_reg] <= grant_instr;
            mem_ch[wr_ptr_reg]    <= grant_idx;
        end
    end

    assign out_pc_o    = out_valid_o ? mem_pc[rd_ptr_reg]    : '0;
    assign out_instr_o = out_valid_o ? mem_instr[rd_ptr_reg] : '0;
    assign out_ch_o    = out_valid_o ? mem_ch[rd_ptr_reg]    : '0;
    assign level_o     = level_reg;
    assign ovf_cnt_o   = ovf_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_drop
            logic [CNT_W-1:0] drop_cnt_reg;
            logic             is_grant;
            logic             drop_inc;

            assign is_grant = grant_valid && (grant_idx == CH_W'(gi));
            assign drop_inc = (req[gi] && !is_grant) || (full_drop && is_grant);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    drop_cnt_reg <= '0;
                end else if (clear_i) begin
                    drop_cnt_reg <= '0;
                end else if (drop_inc && drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
                end
            end

            assign drop_cnt_o[gi*CNT_W +: CNT_W] = drop_cnt_reg;
        end
    endgenerate

endmodule

// File: doc/cv32e41p_trace_fifo.md
Name: cv32e41p_trace_fifo

Overview:
- Multi-channel trace capture buffer. Collects retired-instruction records (pc, instr) from NUM_CH trace sources, one per hart or per observed stage.
- Arbitrates the sources round-robin into one shared first-word-fall-through FIFO. A debug host or log sink drains the FIFO through a valid/ready port.
- Sources cannot be stalled. Records that lose arbitration or cannot be stored are counted per channel, never back-pressured.

Parameters:
- NUM_CH, 2, number of trace source channels (1..8).
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of each saturating per-channel drop counter.
- OVERWRITE, 0, 0 = drop new record when full; 1 = overwrite oldest entry when full.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- capture_en_i  in  1  capture enable; when low, channels are ignored.
- clear_i  in  1  synchronous flush of FIFO, counters and arbiter.
- ch_valid_i  in  NUM_CH  record valid, one bit per channel.
- ch_pc_i  in  NUM_CH x 32  pc per channel.
- ch_instr_i  in  NUM_CH x 32  instruction word per channel.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  sink accepts head.
- out_ch_o  out  $clog2(NUM_CH) (min 1)  source channel of head.
- out_pc_o  out  32  pc of head.
- out_instr_o  out  32  instr of head.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  NUM_CH x CNT_W  per-channel dropped-record counters.
- ovf_cnt_o  out  CNT_W  number of entries overwritten (OVERWRITE=1 only; otherwise 0).

Behaviour:
- Reset (rst_i high, async): FIFO empty, rd/wr pointers 0, level_o=0, out_valid_o=0, round-robin pointer rr=0, all counters 0. out_ch_o/out_pc_o/out_instr_o are 0 while empty.
- Request set: req = ch_valid_i & {NUM_CH{capture_en_i}}.
- Arbitration: grant the first requesting index ≥ rr, wrapping modulo NUM_CH. After any grant, rr <= grant+1 mod NUM_CH; rr holds when there is no request.
- Every requesting non-granted channel increments its drop counter that cycle.
- pop = out_valid_o & out_ready_i.
- Push decision for the granted record:
  - not full: written at wr_ptr.
  - full with pop the same cycle: written; level unchanged.
  - full, no pop, OVERWRITE=0: not written; the granted channel's drop counter increments.
  - full, no pop, OVERWRITE=1: written at wr_ptr; rd_ptr advances; level stays DEPTH; ovf_cnt increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level_o = pushes − pops, range 0..DEPTH.
- Output is first-word-fall-through:
  - out_valid_o = (level_o != 0).
  - Head fields come combinationally from rd_ptr.
  - A record presented in cycle N is visible on the output in cycle N+1 when the FIFO was empty.
- Pop with empty FIFO has no effect (out_valid_o=0).
- Push and pop on an empty FIFO in the same cycle: pop is ignored; the pushed record appears next cycle.
- All counters saturate at all-ones and never wrap.
- clear_i (synchronous) has priority over everything that cycle: FIFO emptied, counters zeroed, rr=0, no push, no pop, no counter increments.
- capture_en_i low: no grants, no drops counted. Draining continues normally.
- Deassertion of capture_en_i mid-stream does not disturb stored entries.
- Reset asserted mid-operation: all state is lost immediately. The output is invalid from the reset edge onward.
- NUM_CH=1: arbiter degenerates; out_ch_o is a constant 0 (width 1).

Test Plan:
- Single channel 0, pc=0x80, instr=0x13, out_ready_i=1 → out_valid_o=1 next cycle with out_pc_o=0x80, out_instr_o=0x13, out_ch_o=0; level_o returns to 0 the following cycle.
- NUM_CH=2, both valid for 4 consecutive cycles, sink ready → grants ch0,ch1,ch0,ch1; drop_cnt_o[0]=2, drop_cnt_o[1]=2; output order ch0,ch1,ch0,ch1.
- OVERWRITE=0, DEPTH=8, out_ready_i=0, 10 records on ch0 (pc 0..9) → level_o=8; drop_cnt_o[0]=2; drain yields pc 0..7.
- OVERWRITE=1, same stimulus → level_o=8; ovf_cnt_o=2; drain yields pc 2..9.
- Full FIFO with simultaneous push and pop → level_o stays 8, no drop counted, head advances by one.
- Counter saturation (CNT_W=2), 5 drops on ch1 → drop_cnt_o[1]=3.
- clear_i asserted while full with a concurrent push → next cycle level_o=0, counters 0, out_valid_o=0.
- Async rst_i pulse mid-drain → outputs clear without waiting for a clock edge.
